// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings and FSM
// state type for the M-extension unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_div_core.sv
// muldiv_div_core: restoring radix-2 divider,
// one quotient bit per cycle on magnitudes.
module muldiv_div_core
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill_i,
  input  logic            start_i,
  input  logic            signed_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  localparam int CW = $clog2(XLEN + 1);

  logic            run_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dvs_q;
  logic            negq_q;
  logic            negr_q;

  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // operand magnitudes and one restoring step
  always_comb begin
    a_neg   = signed_i & dividend_i[XLEN-1];
    b_neg   = signed_i & divisor_i[XLEN-1];
    a_mag   = a_neg ? -dividend_i : dividend_i;
    b_mag   = b_neg ? -divisor_i : divisor_i;
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
  end

  // iteration state: load on start, shift per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else if (kill_i) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (start_i) begin
      run_q  <= 1'b1;
      cnt_q  <= CW'(XLEN);
      quo_q  <= a_mag;
      rem_q  <= '0;
      dvs_q  <= b_mag;
      negq_q <= a_neg ^ b_neg;
      negr_q <= a_neg;
    end else if (run_q) begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
        if (!diff[XLEN]) begin
          rem_q <= diff[XLEN-1:0];
          quo_q <= {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_q <= shifted[XLEN-1:0];
          quo_q <= {quo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        run_q <= 1'b0;
      end
    end
  end

  assign done_o      = run_q & (cnt_q == '0);
  assign quotient_o  = negq_q ? -quo_q : quo_q;
  assign remainder_o = negr_q ? -rem_q : rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32/64 M-extension unit with
// pipelined-latency multiply and iterative divide.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            busy
);

  localparam logic [2:0] MUL_LAST =
    3'(MUL_STAGES - 1);
  localparam logic [XLEN-1:0] MIN_NEG =
    {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q;
  op_e             op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [2:0]      mcnt_q;
  logic            spec_q;
  logic            out_valid_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_out_q;

  logic            accept;
  logic            in_sgn;
  logic            in_zero;
  logic            in_ovf;
  logic            div_start;
  logic            div_done;
  logic [XLEN-1:0] div_quo;
  logic [XLEN-1:0] div_rem;

  logic            sa;
  logic            sb;
  logic [2*XLEN-1:0] a_ext;
  logic [2*XLEN-1:0] b_ext;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] mul_res;
  logic [XLEN-1:0] spec_res;
  logic [XLEN-1:0] div_res;

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign rd_out    = rd_out_q;

  // request decode; divide corner cases skip the core
  always_comb begin
    accept    = in_valid & in_ready & ~flush;
    in_sgn    = ~op[0];
    in_zero   = (rs2 == '0);
    in_ovf    = in_sgn & (rs1 == MIN_NEG) & (&rs2);
    div_start = accept & op[2] & ~in_zero & ~in_ovf;
  end

  // product and result selection from latched operands
  always_comb begin
    sa    = op_q inside {OP_MUL, OP_MULH, OP_MULHSU};
    sb    = op_q inside {OP_MUL, OP_MULH};
    a_ext = {{XLEN{sa & a_q[XLEN-1]}}, a_q};
    b_ext = {{XLEN{sb & b_q[XLEN-1]}}, b_q};
    prod  = a_ext * b_ext;
    if (op_q == OP_MUL) mul_res = prod[XLEN-1:0];
    else                mul_res = prod[2*XLEN-1:XLEN];
    if (b_q == '0) spec_res = op_q[1] ? a_q : '1;
    else           spec_res = op_q[1] ? '0 : a_q;
    div_res = op_q[1] ? div_rem : div_quo;
  end

  muldiv_div_core #(
    .XLEN(XLEN)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .kill_i     (flush),
    .start_i    (div_start),
    .signed_i   (in_sgn),
    .dividend_i (rs1),
    .divisor_i  (rs2),
    .done_o     (div_done),
    .quotient_o (div_quo),
    .remainder_o(div_rem)
  );

  // control FSM with registered result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_MUL;
      a_q         <= '0;
      b_q         <= '0;
      mcnt_q      <= '0;
      spec_q      <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      rd_out_q    <= '0;
    end else if (flush) begin
      state_q     <= S_IDLE;
      mcnt_q      <= '0;
      spec_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q     <= op_e'(op);
            a_q      <= rs1;
            b_q      <= rs2;
            rd_out_q <= rd_in;
            mcnt_q   <= '0;
            spec_q   <= op[2] & (in_zero | in_ovf);
            state_q  <= op[2] ? S_DIV : S_MUL;
          end
        end
        S_MUL: begin
          if (mcnt_q == MUL_LAST) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            result_q    <= mul_res;
          end else begin
            mcnt_q <= mcnt_q + 1'b1;
          end
        end
        S_DIV: begin
          if (spec_q) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            result_q    <= spec_res;
          end else if (div_done) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            result_q    <= div_res;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
